// File: rtl/ring_node_pkg.sv
// Shared port indices, source codes and routing rule for the ring router node.
package ring_node_pkg;

  localparam int PORT_LEFT  = 0;
  localparam int PORT_RIGHT = 1;
  localparam int PORT_SELF  = 2;
  localparam int NUM_PORTS  = 3;

  typedef enum logic [1:0] {
    SRC_NONE = 2'b00,
    SRC_L    = 2'b01,
    SRC_R    = 2'b10,
    SRC_S    = 2'b11
  } srcCode_e;

  // Unsigned destination compare; callers zero-extend narrower fields.
  function automatic logic [1:0] routePort(input logic [15:0] dst, input logic [15:0] nodeId);
    if (dst < nodeId) return 2'(PORT_LEFT);
    if (dst > nodeId) return 2'(PORT_RIGHT);
    return 2'(PORT_SELF);
  endfunction

  function automatic srcCode_e srcCode(input logic [1:0] port);
    return srcCode_e'(port + 2'd1);
  endfunction

endpackage

// File: rtl/node_fifo.sv
// Small input FIFO with a combinational head word so the arbiter can look at it directly.
module node_fifo #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] pushData,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = FIFO_DEPTH[PTR_W:0];

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wrPtr;
  logic [PTR_W-1:0]  rdPtr;
  logic [PTR_W:0]    count;
  logic              doPush;
  logic              doPop;

  assign doPush = push && !full;
  assign doPop  = pop && !empty;
  assign full   = (count == FULL_COUNT);
  assign empty  = (count == '0);
  assign head   = mem[rdPtr];

  // Storage is not reset: the count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PTR_W'(1);
      if (doPop)  rdPtr <= rdPtr + PTR_W'(1);
      case ({doPush, doPop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ring_router_node.sv
// Linear-array router node: three buffered inputs, destination routing, and a
// round-robin arbitrated output register per port with valid/ready handshake.
module ring_router_node
  import ring_node_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 4,
  parameter int NODE_ID    = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              shiftInCLK,
  input  logic              reset,
  input  logic [DATA_W-1:0] shiftInLeftData,
  input  logic              shiftInLeftCS,
  output logic              shiftInLeftReady,
  input  logic [DATA_W-1:0] shiftInRightData,
  input  logic              shiftInRightCS,
  output logic              shiftInRightReady,
  input  logic [DATA_W-1:0] shiftInData,
  input  logic              shiftInCS,
  output logic              shiftInReady,
  output logic [DATA_W-1:0] shiftOutLeftData,
  output logic              shiftOutLeftCS,
  input  logic              shiftOutLeftReady,
  output logic [DATA_W-1:0] shiftOutRightData,
  output logic              shiftOutRightCS,
  input  logic              shiftOutRightReady,
  output logic [DATA_W-1:0] shiftOutData,
  output logic              shiftOutCS,
  input  logic              shiftOutReady,
  output logic [1:0]        dataSource,
  output logic [2:0]        outputSelect
);

  logic [DATA_W-1:0]    inData    [NUM_PORTS];
  logic [DATA_W-1:0]    fifoHead  [NUM_PORTS];
  logic [1:0]           headRoute [NUM_PORTS];
  logic [DATA_W-1:0]    outData   [NUM_PORTS];
  logic [NUM_PORTS-1:0] grant     [NUM_PORTS];
  logic [1:0]           winner    [NUM_PORTS];
  logic [NUM_PORTS-1:0] inCS, inReady, fifoFull, fifoEmpty, fifoPop;
  logic [NUM_PORTS-1:0] outCS, outReady, outGrantAny;
  srcCode_e             srcReg;
  logic [2:0]           selectReg;

  assign inData[PORT_LEFT]  = shiftInLeftData;
  assign inData[PORT_RIGHT] = shiftInRightData;
  assign inData[PORT_SELF]  = shiftInData;
  assign inCS     = {shiftInCS, shiftInRightCS, shiftInLeftCS};
  assign outReady = {shiftOutReady, shiftOutRightReady, shiftOutLeftReady};
  assign inReady  = ~fifoFull & {NUM_PORTS{~reset}};

  assign shiftInLeftReady  = inReady[PORT_LEFT];
  assign shiftInRightReady = inReady[PORT_RIGHT];
  assign shiftInReady      = inReady[PORT_SELF];
  assign shiftOutLeftData  = outData[PORT_LEFT];
  assign shiftOutRightData = outData[PORT_RIGHT];
  assign shiftOutData      = outData[PORT_SELF];
  assign shiftOutLeftCS    = outCS[PORT_LEFT];
  assign shiftOutRightCS   = outCS[PORT_RIGHT];
  assign shiftOutCS        = outCS[PORT_SELF];
  assign dataSource        = srcReg;
  assign outputSelect      = selectReg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : gIn
      node_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
      ) uFifo (
        .clk      (shiftInCLK),
        .reset    (reset),
        .push     (inCS[gi] && inReady[gi]),
        .pushData (inData[gi]),
        .pop      (fifoPop[gi]),
        .full     (fifoFull[gi]),
        .empty    (fifoEmpty[gi]),
        .head     (fifoHead[gi])
      );
      assign headRoute[gi] = routePort(16'(fifoHead[gi][DATA_W-1 -: ADDR_W]), 16'(NODE_ID));
    end

    for (gi = 0; gi < NUM_PORTS; gi++) begin : gOut
      logic [NUM_PORTS-1:0] cand;
      logic [NUM_PORTS-1:0] gnt;
      logic [1:0]           win;
      logic [1:0]           idx;
      logic [2:0]           sum;
      logic [1:0]           rrNext;
      logic [DATA_W-1:0]    dataReg;
      logic                 csReg;
      logic                 load;

      assign load = !csReg || outReady[gi];

      always_comb begin
        cand = '0;
        for (int i = 0; i < NUM_PORTS; i++)
          cand[i] = !fifoEmpty[i] && (headRoute[i] == 2'(gi));
      end

      // Scan L,R,S cyclically from rrNext; first pending head wins.
      always_comb begin
        gnt = '0;
        win = '0;
        idx = '0;
        sum = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
          sum = {1'b0, rrNext} + 3'(k);
          idx = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
          if (gnt == '0 && cand[idx]) begin
            gnt[idx] = 1'b1;
            win      = idx;
          end
        end
        if (!load) gnt = '0;
      end

      always_ff @(posedge shiftInCLK or posedge reset) begin
        if (reset) begin
          dataReg <= '0;
          csReg   <= 1'b0;
          rrNext  <= 2'(PORT_LEFT);
        end else if (load) begin
          csReg <= |gnt;
          if (|gnt) begin
            dataReg <= fifoHead[win];
            rrNext  <= (win == 2'd2) ? 2'd0 : win + 2'd1;
          end
        end
      end

      assign outData[gi]     = dataReg;
      assign outCS[gi]       = csReg;
      assign grant[gi]       = gnt;
      assign winner[gi]      = win;
      assign outGrantAny[gi] = |gnt;
    end
  endgenerate

  // A head routes to exactly one output, so at most one grant per FIFO.
  always_comb begin
    fifoPop = '0;
    for (int o = 0; o < NUM_PORTS; o++) fifoPop = fifoPop | grant[o];
  end

  always_ff @(posedge shiftInCLK or posedge reset) begin
    if (reset) begin
      srcReg    <= SRC_NONE;
      selectReg <= '0;
    end else begin
      selectReg <= outGrantAny;
      if (outGrantAny[PORT_SELF]) srcReg <= srcCode(winner[PORT_SELF]);
    end
  end

endmodule

// File: tb/tb_ring_router_node.sv
// Bench for ring_router_node: directed scenarios plus random traffic against a
// per (input,output) queue scoreboard built from the routing rule.
module tb_ring_router_node;

  localparam int DATA_W = 32, ADDR_W = 4, NODE_ID = 5, FIFO_DEPTH = 4;

  logic        shiftInCLK = 1'b0;
  logic        reset;
  logic [31:0] drvData [3];
  logic [2:0]  drvCS;
  logic [2:0]  drvOutReady;
  logic [31:0] shiftOutLeftData, shiftOutRightData, shiftOutData;
  logic        shiftOutLeftCS, shiftOutRightCS, shiftOutCS;
  logic        shiftInLeftReady, shiftInRightReady, shiftInReady;
  logic [1:0]  dataSource;
  logic [2:0]  outputSelect;

  logic [31:0] outDataV [3];
  logic [2:0]  outCSV, inReadyV;

  assign outDataV[0] = shiftOutLeftData;
  assign outDataV[1] = shiftOutRightData;
  assign outDataV[2] = shiftOutData;
  assign outCSV      = {shiftOutCS, shiftOutRightCS, shiftOutLeftCS};
  assign inReadyV    = {shiftInReady, shiftInRightReady, shiftInLeftReady};

  ring_router_node #(
    .DATA_W (DATA_W), .ADDR_W (ADDR_W), .NODE_ID (NODE_ID), .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .shiftInCLK         (shiftInCLK),
    .reset              (reset),
    .shiftInLeftData    (drvData[0]),
    .shiftInLeftCS      (drvCS[0]),
    .shiftInLeftReady   (shiftInLeftReady),
    .shiftInRightData   (drvData[1]),
    .shiftInRightCS     (drvCS[1]),
    .shiftInRightReady  (shiftInRightReady),
    .shiftInData        (drvData[2]),
    .shiftInCS          (drvCS[2]),
    .shiftInReady       (shiftInReady),
    .shiftOutLeftData   (shiftOutLeftData),
    .shiftOutLeftCS     (shiftOutLeftCS),
    .shiftOutLeftReady  (drvOutReady[0]),
    .shiftOutRightData  (shiftOutRightData),
    .shiftOutRightCS    (shiftOutRightCS),
    .shiftOutRightReady (drvOutReady[1]),
    .shiftOutData       (shiftOutData),
    .shiftOutCS         (shiftOutCS),
    .shiftOutReady      (drvOutReady[2]),
    .dataSource         (dataSource),
    .outputSelect       (outputSelect)
  );

  always #5 shiftInCLK = ~shiftInCLK;

  int checks = 0;
  int errors = 0;
  logic [31:0] expQ [9][$];   // index = source*3 + destination port

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int routeOf(input logic [31:0] w);
    int dst;
    dst = int'(w[31:28]);
    if (dst < NODE_ID) return 0;
    if (dst > NODE_ID) return 1;
    return 2;
  endfunction

  function automatic int pendingWords();
    int n;
    n = 0;
    for (int q = 0; q < 9; q++) n += expQ[q].size();
    return n;
  endfunction

  // Scoreboard: transfers and pushes are both committed at the next rising edge.
  always @(negedge shiftInCLK) begin
    int found;
    if (reset) begin
      for (int q = 0; q < 9; q++) expQ[q].delete();
    end else begin
      for (int o = 0; o < 3; o++) begin
        if (outCSV[o] && drvOutReady[o]) begin
          found = -1;
          for (int s = 0; s < 3; s++)
            if (found < 0 && expQ[s*3+o].size() > 0 && expQ[s*3+o][0] == outDataV[o]) found = s;
          checkEq($sformatf("sb_out%0d_word_expected", o), 32'(found >= 0), 32'd1);
          if (found >= 0) begin
            void'(expQ[found*3+o].pop_front());
            if (o == 2) checkEq("sb_dataSource", 32'(dataSource), 32'(found + 1));
          end else begin
            $display("  unexpected word %h on output %0d", outDataV[o], o);
          end
        end
      end
      for (int i = 0; i < 3; i++)
        if (drvCS[i] && inReadyV[i]) expQ[i*3+routeOf(drvData[i])].push_back(drvData[i]);
    end
  end

  task automatic tick();
    @(posedge shiftInCLK);
    #1;
  endtask

  // Reset asserted and released in the middle of a clock high phase.
  task automatic resetMid(input string tag);
    #2 reset = 1'b1;
    #1;
    checkEq({tag, "_outCS_cleared"}, 32'(outCSV), 32'd0);
    checkEq({tag, "_outData_cleared"}, outDataV[0] | outDataV[1] | outDataV[2], 32'd0);
    checkEq({tag, "_inReady_low"}, 32'(inReadyV), 32'd0);
    @(posedge shiftInCLK);
    #2 reset = 1'b0;
    #1;
    checkEq({tag, "_inReady_after_release"}, 32'(inReadyV), 32'd7);
    checkEq({tag, "_dataSource_reset"}, 32'(dataSource), 32'd0);
    checkEq({tag, "_outputSelect_reset"}, 32'(outputSelect), 32'd0);
  endtask

  // Six dest-9 words on the left input with the right output stalled.
  task automatic fillBacklog(input string tag);
    int n;
    logic acc;
    n = 1;
    drvOutReady[1] = 1'b0;
    for (int c = 0; c < 10; c++) begin
      drvData[0] = 32'h9000_0000 + 32'(n);
      drvCS[0]   = 1'b1;
      acc        = shiftInLeftReady;
      tick();
      if (acc) n++;
    end
    checkEq({tag, "_accepted_count"}, 32'(n - 1), 32'd5);
    checkEq({tag, "_inLeftReady_full"}, 32'(shiftInLeftReady), 32'd0);
    checkEq({tag, "_outRight_held_cs"}, 32'(shiftOutRightCS), 32'd1);
    checkEq({tag, "_outRight_held_data"}, shiftOutRightData, 32'h9000_0001);
  endtask

  logic [31:0] t3Words [3];
  logic [2:0]  pending;
  logic [2:0]  acc3;
  int          rrSelf, pick, seq, dst;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    reset       = 1'b1;
    drvCS       = '0;
    drvOutReady = 3'b111;
    for (int i = 0; i < 3; i++) drvData[i] = '0;
    #2;
    checkEq("por_outCS", 32'(outCSV), 32'd0);
    checkEq("por_inReady_low", 32'(inReadyV), 32'd0);
    @(posedge shiftInCLK);
    #2 reset = 1'b0;
    #1;
    checkEq("por_inReady", 32'(inReadyV), 32'd7);
    checkEq("por_outputSelect", 32'(outputSelect), 32'd0);
    checkEq("por_dataSource", 32'(dataSource), 32'd0);
    tick();

    // Test 1: reset while the left output holds a stalled word
    drvOutReady[0] = 1'b0;
    drvData[1] = 32'h2000_0011; drvCS[1] = 1'b1;
    drvData[2] = 32'h9000_0022; drvCS[2] = 1'b1;
    tick();
    drvCS = '0;
    tick();
    checkEq("t1_pre_outLeftCS", 32'(shiftOutLeftCS), 32'd1);
    resetMid("t1");
    drvOutReady = 3'b111;
    tick();
    tick();
    checkEq("t1_no_stale", 32'(outCSV), 32'd0);

    // Test 2: right-in word addressed below NODE_ID exits left after two edges
    drvData[1] = 32'h3000_002A; drvCS[1] = 1'b1;
    tick();
    drvCS[1] = 1'b0;
    checkEq("t2_outLeftCS_edge1", 32'(shiftOutLeftCS), 32'd0);
    tick();
    checkEq("t2_outLeftCS_edge2", 32'(shiftOutLeftCS), 32'd1);
    checkEq("t2_outLeftData", shiftOutLeftData, 32'h3000_002A);
    checkEq("t2_outputSelect", 32'(outputSelect), 32'b001);
    tick();
    checkEq("t2_outLeftCS_consumed", 32'(shiftOutLeftCS), 32'd0);
    checkEq("t2_outputSelect_pulse", 32'(outputSelect), 32'b000);

    // Test 3: three sources contend for the self output, two rounds
    t3Words[0] = 32'h5000_0049; t3Words[1] = 32'h5000_0059; t3Words[2] = 32'h5000_0004;
    rrSelf = 0;
    for (int rep = 0; rep < 2; rep++) begin
      for (int i = 0; i < 3; i++) begin drvData[i] = t3Words[i]; drvCS[i] = 1'b1; end
      tick();
      drvCS = '0;
      pending = 3'b111;
      for (int n = 0; n < 3; n++) begin
        pick = -1;
        for (int k = 0; k < 3; k++)
          if (pick < 0 && pending[(rrSelf + k) % 3]) pick = (rrSelf + k) % 3;
        pending[pick] = 1'b0;
        rrSelf = (pick + 1) % 3;
        tick();
        checkEq($sformatf("t3_r%0d_self_cs%0d", rep, n), 32'(shiftOutCS), 32'd1);
        checkEq($sformatf("t3_r%0d_self_data%0d", rep, n), shiftOutData, t3Words[pick]);
        checkEq($sformatf("t3_r%0d_dataSource%0d", rep, n), 32'(dataSource), 32'(pick + 1));
      end
      tick();
      checkEq($sformatf("t3_r%0d_self_idle", rep), 32'(shiftOutCS), 32'd0);
    end

    // Test 4: backpressure fills the left FIFO, then drains one word per cycle
    fillBacklog("t4");
    drvOutReady[1] = 1'b1;
    for (int m = 2; m <= 6; m++) begin
      acc3[0] = drvCS[0] && shiftInLeftReady;
      tick();
      if (acc3[0]) drvCS[0] = 1'b0;
      checkEq($sformatf("t4_drain_cs%0d", m), 32'(shiftOutRightCS), 32'd1);
      checkEq($sformatf("t4_drain_data%0d", m), shiftOutRightData, 32'h9000_0000 + 32'(m));
    end
    checkEq("t4_sender_released", 32'(drvCS[0]), 32'd0);
    tick();
    checkEq("t4_outRight_idle", 32'(shiftOutRightCS), 32'd0);
    checkEq("t4_inLeftReady_back", 32'(shiftInLeftReady), 32'd1);

    // Test 5: two outputs load on the same edge
    drvData[0] = 32'h9000_0077; drvCS[0] = 1'b1;
    drvData[1] = 32'h1000_0088; drvCS[1] = 1'b1;
    tick();
    drvCS = '0;
    tick();
    checkEq("t5_right_cs", 32'(shiftOutRightCS), 32'd1);
    checkEq("t5_left_cs", 32'(shiftOutLeftCS), 32'd1);
    checkEq("t5_right_data", shiftOutRightData, 32'h9000_0077);
    checkEq("t5_left_data", shiftOutLeftData, 32'h1000_0088);
    checkEq("t5_outputSelect", 32'(outputSelect), 32'b011);
    tick();

    // Test 6: reset discards a full backlog
    fillBacklog("t6");
    drvCS = '0;
    resetMid("t6");
    drvOutReady = 3'b111;
    for (int c = 0; c < 8; c++) begin
      tick();
      checkEq($sformatf("t6_no_stale_c%0d", c), 32'(outCSV), 32'd0);
    end

    // Random traffic with held senders and random downstream stalls
    seq = 0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (!drvCS[i] && $urandom_range(0, 9) < 6) begin
          dst        = int'($urandom_range(0, 15));
          drvData[i] = {4'(dst), 2'(i), 26'(seq)};
          drvCS[i]   = 1'b1;
          seq++;
        end
      end
      for (int o = 0; o < 3; o++) drvOutReady[o] = ($urandom_range(0, 3) != 0);
      acc3 = drvCS & inReadyV;
      tick();
      for (int i = 0; i < 3; i++) if (acc3[i]) drvCS[i] = 1'b0;
    end
    drvCS = '0;
    drvOutReady = 3'b111;
    for (int c = 0; c < 100 && pendingWords() != 0; c++) tick();
    tick();
    tick();
    checkEq("rand_drain_all_delivered", 32'(pendingWords()), 32'd0);
    checkEq("rand_outputs_idle", 32'(outCSV), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
